// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency single-port memory between
// the instruction-fetch (IF) and load/store (LS) requesters.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned MEM_LAT = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic              if_gnt_o,
   output logic              if_rvalid_o,
   output logic [DATA_W-1:0] if_rdata_o,
   input  logic              ls_req_i,
   input  logic              ls_we_i,
   input  logic [ADDR_W-1:0] ls_addr_i,
   input  logic [DATA_W-1:0] ls_wdata_i,
   output logic              ls_gnt_o,
   output logic              ls_rvalid_o,
   output logic [DATA_W-1:0] ls_rdata_o,
   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              busy_o
);

   localparam int unsigned CntW = $clog2(MEM_LAT + 1);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   state_e            state_q, state_d;
   logic              owner_ls_q, owner_ls_d;  // 1: LS owns the transaction
   logic              last_ls_q, last_ls_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;

   logic pick_ls;
   logic any_req;

   // On a conflict the port that did not win last time gets the grant.
   assign pick_ls = ls_req_i & (~if_req_i | ~last_ls_q);
   assign any_req = if_req_i | ls_req_i;

   always_comb begin
      state_d     = state_q;
      owner_ls_d  = owner_ls_q;
      last_ls_d   = last_ls_q;
      addr_d      = addr_q;
      we_d        = we_q;
      wdata_d     = wdata_q;
      cnt_d       = cnt_q;
      if_rdata_d  = if_rdata_q;
      ls_rdata_d  = ls_rdata_q;
      if_gnt_o    = 1'b0;
      ls_gnt_o    = 1'b0;
      if_rvalid_o = 1'b0;
      ls_rvalid_o = 1'b0;
      mem_en_o    = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      busy_o      = 1'b0;

      unique case (state_q)
         StIdle, StResp: begin
            if (state_q == StResp) begin
               if_rvalid_o = ~owner_ls_q;
               ls_rvalid_o = owner_ls_q;
            end
            if (any_req) begin
               owner_ls_d = pick_ls;
               last_ls_d  = pick_ls;
               addr_d     = pick_ls ? ls_addr_i : if_addr_i;
               we_d       = pick_ls & ls_we_i;
               wdata_d    = pick_ls ? ls_wdata_i : '0;
               state_d    = StIssue;
            end else begin
               state_d = StIdle;
            end
         end
         StIssue: begin
            busy_o      = 1'b1;
            mem_en_o    = 1'b1;
            mem_we_o    = we_q;
            mem_addr_o  = addr_q;
            mem_wdata_o = wdata_q;
            if_gnt_o    = ~owner_ls_q;
            ls_gnt_o    = owner_ls_q;
            cnt_d       = CntW'(MEM_LAT - 1);
            state_d     = StWait;
         end
         StWait: begin
            busy_o = 1'b1;
            if (cnt_q == '0) begin
               if (owner_ls_q) begin
                  ls_rdata_d = we_q ? '0 : mem_rdata_i;
               end else begin
                  if_rdata_d = mem_rdata_i;
               end
               state_d = StResp;
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         owner_ls_q <= 1'b0;
         last_ls_q  <= 1'b0;
         addr_q     <= '0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         cnt_q      <= '0;
         if_rdata_q <= '0;
         ls_rdata_q <= '0;
      end else begin
         state_q    <= state_d;
         owner_ls_q <= owner_ls_d;
         last_ls_q  <= last_ls_d;
         addr_q     <= addr_d;
         we_q       <= we_d;
         wdata_q    <= wdata_d;
         cnt_q      <= cnt_d;
         if_rdata_q <= if_rdata_d;
         ls_rdata_q <= ls_rdata_d;
      end
   end

   assign if_rdata_o = if_rdata_q;
   assign ls_rdata_o = ls_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: a MEM_LAT=2 instance for most scenarios and a MEM_LAT=1
// instance for back-to-back fetches, each fed by a small latency-accurate memory.
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // MEM_LAT=2 instance signals
   logic        if_req = 0, ls_req = 0, ls_we = 0;
   logic [31:0] if_addr = 0, ls_addr = 0, ls_wdata = 0;
   logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_en, mem_we, busy;
   logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata, mem_rdata;

   // MEM_LAT=1 instance signals
   logic        b_if_req = 0;
   logic [31:0] b_if_addr = 0;
   logic        b_if_gnt, b_if_rvalid, b_ls_gnt, b_ls_rvalid, b_mem_en, b_mem_we, b_busy;
   logic [31:0] b_if_rdata, b_ls_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
      .clk_i(clk), .rst_i(rst),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
      .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
      .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_addr_i(ls_addr), .ls_wdata_i(ls_wdata),
      .ls_gnt_o(ls_gnt), .ls_rvalid_o(ls_rvalid), .ls_rdata_o(ls_rdata),
      .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .busy_o(busy)
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
      .clk_i(clk), .rst_i(rst),
      .if_req_i(b_if_req), .if_addr_i(b_if_addr), .if_gnt_o(b_if_gnt),
      .if_rvalid_o(b_if_rvalid), .if_rdata_o(b_if_rdata),
      .ls_req_i(1'b0), .ls_we_i(1'b0), .ls_addr_i(32'h0), .ls_wdata_i(32'h0),
      .ls_gnt_o(b_ls_gnt), .ls_rvalid_o(b_ls_rvalid), .ls_rdata_o(b_ls_rdata),
      .mem_en_o(b_mem_en), .mem_we_o(b_mem_we), .mem_addr_o(b_mem_addr),
      .mem_wdata_o(b_mem_wdata), .mem_rdata_i(b_mem_rdata), .busy_o(b_busy)
   );

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      if (a == 32'h100) return 32'hDEADBEEF;
      if (a == 32'h40)  return 32'hCAFEF00D;
      return a ^ 32'h5A5A0000;
   endfunction

   // Memory models: data valid exactly MEM_LAT cycles after mem_en, junk otherwise.
   logic        v1 = 0, v2 = 0, bv1 = 0;
   logic [31:0] d1 = 0, d2 = 0, bd1 = 0;
   always_ff @(posedge clk) begin
      v1  <= mem_en;
      d1  <= mem_val(mem_addr);
      v2  <= v1;
      d2  <= d1;
      bv1 <= b_mem_en;
      bd1 <= mem_val(b_mem_addr);
   end
   assign mem_rdata   = v2  ? d2  : 32'hBAD0BAD0;
   assign b_mem_rdata = bv1 ? bd1 : 32'hBAD0BAD0;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
   endtask

   int          pulse_cyc[8];
   logic        pulse_ls[8];
   int          n_pulse;
   logic        overlap;
   logic        saw_rvalid;

   initial begin
      do_reset();
      // Reset state
      check_eq("rst_ctrl", {if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_en, mem_we, busy}, 0);
      check_eq("rst_rdata", {if_rdata, ls_rdata}, 0);
      check_eq("rst_mem", {mem_addr, mem_wdata}, 0);

      // 1: fetch alone
      if_req = 1; if_addr = 32'h100;
      tick();
      check_eq("t1_issue", {if_gnt, mem_en, mem_we, ls_gnt, busy}, 5'b11001);
      check_eq("t1_addr", mem_addr, 32'h100);
      if_req = 0;
      tick();
      check_eq("t1_wait", {mem_en, if_gnt, busy}, 3'b001);
      tick(2);
      check_eq("t1_resp", {if_rvalid, ls_rvalid, busy}, 3'b100);
      check_eq("t1_rdata", if_rdata, 32'hDEADBEEF);
      check_eq("t1_ls_quiet", ls_rdata, 0);
      tick();
      check_eq("t1_idle", {if_rvalid, busy}, 0);
      check_eq("t1_hold", if_rdata, 32'hDEADBEEF);

      // 2: first conflict after reset goes to LS
      do_reset();
      if_req = 1; if_addr = 32'h104;
      ls_req = 1; ls_we = 0; ls_addr = 32'h40;
      tick();
      check_eq("t2_gnt_ls", {ls_gnt, if_gnt}, 2'b10);
      check_eq("t2_addr_ls", mem_addr, 32'h40);
      ls_req = 0;
      tick(3);
      check_eq("t2_resp_ls", {ls_rvalid, if_rvalid}, 2'b10);
      check_eq("t2_ls_rdata", ls_rdata, 32'hCAFEF00D);
      tick();
      check_eq("t2_gnt_if", {if_gnt, ls_gnt, mem_en}, 3'b101);
      check_eq("t2_addr_if", mem_addr, 32'h104);
      if_req = 0;
      tick(3);
      check_eq("t2_resp_if", {if_rvalid, ls_rvalid}, 2'b10);
      check_eq("t2_if_rdata", if_rdata, 32'h5A5A0104);
      tick();

      // 3: store
      ls_req = 1; ls_we = 1; ls_addr = 32'h80; ls_wdata = 32'h12345678;
      tick();
      check_eq("t3_issue", {mem_en, mem_we, ls_gnt, if_gnt}, 4'b1110);
      check_eq("t3_wdata", mem_wdata, 32'h12345678);
      check_eq("t3_addr", mem_addr, 32'h80);
      ls_req = 0; ls_we = 0;
      tick(3);
      check_eq("t3_ack", {ls_rvalid, if_rvalid}, 2'b10);
      check_eq("t3_rdata0", ls_rdata, 0);
      tick();

      // 4: continuous conflict, alternating grants
      do_reset();
      if_req = 1; if_addr = 32'h200;
      ls_req = 1; ls_we = 0; ls_addr = 32'h300;
      n_pulse = 0; overlap = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if ((if_gnt & ls_gnt) | (if_rvalid & ls_rvalid)) overlap = 1;
         if (mem_en && n_pulse < 8) begin
            pulse_cyc[n_pulse] = i;
            pulse_ls[n_pulse]  = ls_gnt;
            n_pulse++;
         end
      end
      check_eq("t4_count", n_pulse, 5);
      check_eq("t4_overlap", overlap, 0);
      for (int k = 0; k < 4; k++) begin
         check_eq($sformatf("t4_owner%0d", k), pulse_ls[k], (k % 2 == 0) ? 1 : 0);
      end
      for (int k = 1; k < 4; k++) begin
         check_eq($sformatf("t4_gap%0d", k), pulse_cyc[k] - pulse_cyc[k-1], 4);
      end
      if_req = 0; ls_req = 0;
      tick(6);

      // 5: reset during WAIT of a load
      ls_req = 1; ls_we = 0; ls_addr = 32'h40;
      tick();
      check_eq("t5_gnt", ls_gnt, 1);
      ls_req = 0;
      tick();
      rst = 1;
      tick();
      rst = 0;
      check_eq("t5_ctrl0", {if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_en, mem_we, busy}, 0);
      check_eq("t5_rdata0", {if_rdata, ls_rdata}, 0);
      saw_rvalid = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (ls_rvalid | if_rvalid | busy) saw_rvalid = 1;
      end
      check_eq("t5_no_rvalid", saw_rvalid, 0);
      check_eq("t5_rdata_ign", ls_rdata, 0);
      if_req = 1; if_addr = 32'h8; ls_req = 1; ls_addr = 32'h44;
      tick();
      check_eq("t5_conflict_ls", {ls_gnt, if_gnt}, 2'b10);
      if_req = 0; ls_req = 0;
      tick(8);

      // 6: MEM_LAT=1 back-to-back fetches
      b_if_req = 1; b_if_addr = 32'h0;
      tick();
      check_eq("t6_en0", {b_mem_en, b_if_gnt}, 2'b11);
      check_eq("t6_addr0", b_mem_addr, 32'h0);
      b_if_addr = 32'h4;
      tick();
      check_eq("t6_wait0", {b_mem_en, b_if_rvalid}, 0);
      tick();
      check_eq("t6_rv0", {b_if_rvalid, b_mem_en}, 2'b10);
      check_eq("t6_rd0", b_if_rdata, 32'h5A5A0000);
      tick();
      check_eq("t6_en1", {b_mem_en, b_if_gnt}, 2'b11);
      check_eq("t6_addr1", b_mem_addr, 32'h4);
      b_if_req = 0;
      tick(2);
      check_eq("t6_rv1", b_if_rvalid, 1);
      check_eq("t6_rd1", b_if_rdata, 32'h5A5A0004);
      check_eq("t6_ls_quiet", {b_ls_rvalid, b_ls_gnt}, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
